// File: rtl/inv_syn_sched.sv
// -----------------------------------------------------------------------------
// inv_syn_sched
//
// Serial inversion-count engine shared by two requesters. It accepts one
// N-symbol DNA word (2 bits per symbol, symbol x0 in the top bits) through a
// valid/ready handshake. It then compares one symbol pair (i, j), i < j, per
// cycle, and returns the number of pairs with x_i > x_j on a valid/ready
// result port. The result is tagged with the id of the requester that
// supplied the word.
//
// Arbitration:
//   INV_SYN_RR_EN defined   : round-robin. On a tie, the requester that was
//                             not served last wins. last_id resets to 1, so
//                             requester 0 wins the first tie after reset.
//   INV_SYN_RR_EN undefined : fixed priority. Requester 0 wins whenever it
//                             is valid.
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   req0_valid/ready/word  requester 0 word handshake (2N-bit word)
//   req1_valid/ready/word  requester 1 word handshake (2N-bit word)
//   res_valid/res_ready    result handshake
//   res_sum                inversion count (SUM_W bits)
//   res_id                 requester that supplied the word
//   busy                   high while a word is being processed or held
// -----------------------------------------------------------------------------
module inv_syn_sched #(
    parameter int N     = 6,
    parameter int SUM_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2*N-1:0]   req0_word,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2*N-1:0]   req1_word,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic             res_id,
    output logic             busy
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(N - 2);
    localparam logic [IW-1:0] LAST_J = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*N-1:0]     word_q, word_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;
    logic               id_q, id_d;
    logic [SUM_W-1:0]   res_sum_q, res_sum_d;
    logic               res_id_q, res_id_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic               grant;
    logic [1:0]         x_i, x_j;
    logic [SUM_W-1:0]   acc_next;

`ifdef INV_SYN_RR_EN
    logic               last_id_q, last_id_d;
`endif

    // Symbol k of a word; symbol 0 sits in the most significant bits.
    function automatic logic [1:0] sym(input logic [2*N-1:0] w, input logic [IW-1:0] k);
        return w[(2*N-1) - 2*int'(k) -: 2];
    endfunction

    // Grant is purely a function of the current valids, so a requester that
    // drops valid before its handshake simply loses the grant.
    always_comb begin
`ifdef INV_SYN_RR_EN
        grant = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
`else
        grant = ~req0_valid;
`endif
    end

    // Readies are gated by rst_n so that no word is offered while reset is held.
    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant;

    assign x_i      = sym(word_q, i_q);
    assign x_j      = sym(word_q, j_q);
    assign acc_next = acc_q + SUM_W'(x_i > x_j);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        id_d        = id_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;
`ifdef INV_SYN_RR_EN
        last_id_d   = last_id_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    word_d  = grant ? req1_word : req0_word;
                    id_d    = grant;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = IW'(1);
                    state_d = RUN;
                    busy_d  = 1'b1;
`ifdef INV_SYN_RR_EN
                    last_id_d = grant;
`endif
                end
            end
            RUN: begin
                acc_d = acc_next;
                if (i_q == LAST_I && j_q == LAST_J) begin
                    // Final pair: publish the result in a separate register
                    // so it stays put after the engine returns to IDLE.
                    state_d     = DONE;
                    res_sum_d   = acc_next;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                end else if (j_q == LAST_J) begin
                    // End of row: start the next row at the pair (i+1, i+2).
                    i_d = i_q + IW'(1);
                    j_d = i_q + IW'(2);
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            id_q        <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_SYN_RR_EN
            last_id_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            id_q        <= id_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
`ifdef INV_SYN_RR_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_syn_sched.sv
// -----------------------------------------------------------------------------
// Testbench for inv_syn_sched (N=6, SUM_W=14).
// A transaction-level model (inversion count by double loop, fixed
// result latency) is compared with the DUT outputs on every falling edge.
// Directed scenarios add hand-computed literal expectations. They are
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_inv_syn_sched;
    localparam int N     = 6;
    localparam int SUM_W = 14;
    localparam int L     = N * (N - 1) / 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [2*N-1:0]   req0_word;
    logic             req1_valid, req1_ready;
    logic [2*N-1:0]   req1_word;
    logic             res_valid, res_ready;
    logic [SUM_W-1:0] res_sum;
    logic             res_id;
    logic             busy;

    inv_syn_sched #(.N(N), .SUM_W(SUM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_word  (req0_word),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_word  (req1_word),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] W_A = 12'b01_10_11_01_10_11; // [1,2,3,1,2,3] -> 3
    localparam logic [11:0] W_B = 12'b00_11_10_01_00_11; // [0,3,2,1,0,3] -> 6
    localparam logic [11:0] W_C = 12'b10_11_11_00_00_01; // [2,3,3,0,0,1] -> 9
    localparam logic [11:0] W_D = 12'b11_11_10_10_01_00; // [3,3,2,2,1,0] -> 13

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: count pairs i<j with x_i > x_j.
    function automatic int inv_count(input logic [2*N-1:0] w);
        int s;
        int xs [N];
        s = 0;
        for (int k = 0; k < N; k++) xs[k] = int'((w >> (2 * (N - 1 - k))) & 3);
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (xs[a] > xs[b]) s++;
        return s;
    endfunction

    // ---------------- model state (timeline of one transaction) ----------------
    bit m_live = 0;
    int m_cnt  = 0;     // 0 idle, 1..L computing, L+1 result presented
    int m_sum  = 0;
    int m_id   = 0;
    int m_rsum = 0;
    int m_rid  = 0;
    int m_last = 1;

    int got_sum[$];
    int got_id[$];
    bit r1_seen = 0;

    always @(negedge clk) begin
        bit g, e_r0, e_r1;
`ifdef INV_SYN_RR_EN
        g = (req0_valid && req1_valid) ? (m_last == 0) : req1_valid;
`else
        g = !req0_valid;
`endif
        e_r0 = rst_n && (m_cnt == 0) && req0_valid && !g;
        e_r1 = rst_n && (m_cnt == 0) && req1_valid &&  g;

        if (m_live) begin
            chk("req0_ready", int'(req0_ready), int'(e_r0));
            chk("req1_ready", int'(req1_ready), int'(e_r1));
            chk("res_valid",  int'(res_valid),  int'(m_cnt == L + 1));
            chk("busy",       int'(busy),       int'(m_cnt != 0));
            chk("res_sum",    int'(res_sum),    m_rsum);
            chk("res_id",     int'(res_id),     m_rid);
        end

        if (res_valid && res_ready && rst_n) begin
            got_sum.push_back(int'(res_sum));
            got_id.push_back(int'(res_id));
        end
        if (req1_ready) r1_seen = 1;

        if (!rst_n) begin
            m_live = 1; m_cnt = 0; m_rsum = 0; m_rid = 0; m_last = 1;
        end else if (m_live) begin
            if (m_cnt == 0) begin
                if (e_r0 || e_r1) begin
                    m_cnt  = 1;
                    m_id   = e_r1 ? 1 : 0;
                    m_sum  = inv_count(e_r1 ? req1_word : req0_word);
                    m_last = m_id;
                end
            end else if (m_cnt < L) begin
                m_cnt++;
            end else if (m_cnt == L) begin
                m_cnt = L + 1; m_rsum = m_sum; m_rid = m_id;
            end else if (res_ready) begin
                m_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word on requester 0 until accepted; returns in cycle T+1.
    task automatic accept0(input logic [2*N-1:0] w);
        int k;
        req0_word  = w;
        req0_valid = 1'b1;
        #1;
        k = 0;
        while (!req0_ready && k < 60) begin tick(); k++; end
        if (!req0_ready) chk("accept0_timeout", 0, 1);
        tick();
        req0_valid = 1'b0;
    endtask

    // Count cycles from T+1 until res_valid is seen (T+n).
    task automatic wait_valid(output int n);
        n = 1;
        while (!res_valid && n < 60) begin tick(); n++; end
    endtask

    task automatic wait_results(input int cnt, input int budget);
        int k;
        k = 0;
        while (got_sum.size() < cnt && k < budget) begin tick(); k++; end
        if (got_sum.size() < cnt) chk("results_timeout", got_sum.size(), cnt);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 60) begin tick(); k++; end
        chk("drain_idle", int'(busy), 0);
    endtask

    task automatic show(input string nm);
        $display("txn %s: res_sum=%0d res_id=%0d", nm, res_sum, res_id);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcount;
        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_word = W_B; req1_word = W_C;

        // Model pins.
        chk("pin_A", inv_count(W_A), 3);
        chk("pin_B", inv_count(W_B), 6);
        chk("pin_C", inv_count(W_C), 9);
        chk("pin_D", inv_count(W_D), 13);

        // Reset held two cycles with both valids high.
        tick(); tick();
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);
        chk("rst_res_valid",  int'(res_valid), 0);
        chk("rst_res_sum",    int'(res_sum), 0);
        chk("rst_res_id",     int'(res_id), 0);
        chk("rst_busy",       int'(busy), 0);
        rst_n = 1'b1;
        #1;
        chk("first_idle_req0_ready", int'(req0_ready), 1);
        chk("first_idle_req1_ready", int'(req1_ready), 0);

        // Contention straight after reset.
        got_sum.delete(); got_id.delete(); r1_seen = 0;
        wait_results(3, 3 * (L + 2) + 10);
        if (got_sum.size() >= 3) begin
            $display("txn contention: %0d/%0d %0d/%0d %0d/%0d",
                     got_sum[0], got_id[0], got_sum[1], got_id[1], got_sum[2], got_id[2]);
            chk("cont0_sum", got_sum[0], 6); chk("cont0_id", got_id[0], 0);
`ifdef INV_SYN_RR_EN
            chk("cont1_sum", got_sum[1], 9); chk("cont1_id", got_id[1], 1);
            chk("cont2_sum", got_sum[2], 6); chk("cont2_id", got_id[2], 0);
`else
            chk("cont1_id", got_id[1], 0); chk("cont2_id", got_id[2], 0);
            chk("cont_req1_starved", int'(r1_seen), 0);
`endif
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Single word, res_ready high.
        res_ready = 1'b1;
        accept0(W_A);
        wait_valid(n);
        show("single");
        chk("single_latency", n, L + 1);
        chk("single_sum", int'(res_sum), 3);
        chk("single_id", int'(res_id), 0);
        tick();
        chk("single_busy_after", int'(busy), 0);

        // Backpressure: result held for 5 cycles, both requesters waiting.
        res_ready = 1'b0;
        accept0(W_A);
        req0_valid = 1'b1; req1_valid = 1'b1; req1_word = W_C;
        wait_valid(n);
        chk("bp_latency", n, L + 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(res_valid), 1);
            chk("bp_sum", int'(res_sum), 3);
            chk("bp_id", int'(res_id), 0);
            chk("bp_readies", int'(req0_ready) + int'(req1_ready), 0);
            tick();
        end
        show("backpressure");
        res_ready = 1'b1;
        tick();
        chk("bp_idle_busy", int'(busy), 0);
        chk("bp_idle_ready", int'(req0_ready) + int'(req1_ready), 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Reset in the middle of a run.
        accept0(W_A);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        vcount = 0;
        for (int k = 0; k < 25; k++) begin
            if (res_valid) vcount++;
            tick();
        end
        chk("midrst_no_result", vcount, 0);
        accept0(W_D);
        wait_valid(n);
        show("after_reset");
        chk("midrst_next_sum", int'(res_sum), 13);
        tick();

        // All-zero word.
        accept0('0);
        wait_valid(n);
        show("zeros");
        chk("zeros_sum", int'(res_sum), 0);
        tick();

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_word  = 12'($urandom);
            req1_word  = 12'($urandom);
            res_ready  = ($urandom_range(0, 2) != 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inv_syn_sched.md
# inv_syn_sched

Shared, serial inversion-sum engine with a two-requester arbiter. It accepts N-symbol DNA words (2 bits per symbol) from two requesters over valid/ready handshakes. It computes the inversion count by stepping one symbol pair per cycle, and returns a tagged result over a valid/ready result port. It sits between the word sources and the syndrome consumers in place of a fully combinational inversion-sum unit, and trades latency for area.

## Interface
- N, default 6: symbols per word; N ≥ 2.
- SUM_W, default 14: result width; must satisfy N(N-1)/2 < 2^SUM_W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has a word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req0_word  in  2N  requester 0 word, symbol x0 in bits [2N-1:2N-2].
- req1_valid / req1_ready / req1_word: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_sum  out  SUM_W  inversion count.
- res_id  out  1  requester that supplied the word.
- busy  out  1  high in RUN and DONE.

## Operation
- Symbol k of a word: x_k = word[2N-1-2k -: 2], unsigned. Result = number of pairs i<j with x_i > x_j. Equal symbols are not inversions.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - grant = arbiter pick among the valid requesters.
  - reqX_ready = (state==IDLE) && valid_X && grant==X. At most one ready is high at a time.
  - On handshake: latch word, set id = X, acc = 0, i = 0, j = 1, last_id = X, then go to RUN.
- RUN:
  - Each cycle: acc += (x_i > x_j).
  - If j == N-1, then i ← i+1 and j ← i+2. Otherwise j ← j+1.
  - After the pair (N-2, N-1) is compared, go to DONE with the final acc.
- DONE: res_valid = 1. res_sum and res_id hold stable until res_ready is high, then go to IDLE.
- Both reqX_ready stay low outside IDLE.
- A requester may drop valid before its handshake. Grant is re-evaluated every cycle and no state changes without a handshake.
- res_sum and res_id keep their last value after DONE. They are defined only while res_valid is high.
- Reset values: state IDLE, req0_ready = req1_ready = 0, res_valid = 0, res_sum = 0, res_id = 0, busy = 0, last_id = 1.
- Reset asserted during RUN or DONE discards the word in flight. No result is produced for it.

## Timing
- Handshake at cycle T.
- RUN occupies cycles T+1 to T+N(N-1)/2; for N=6 that is T+1..T+15.
- res_valid is high from cycle T+N(N-1)/2+1; for N=6 that is T+16.
- If res_ready is high in the first DONE cycle U, state is IDLE at U+1 and a new handshake is possible at U+1.
- Minimum spacing between accepts is N(N-1)/2+2 cycles (17 for N=6).
- Reset takes effect on the next clock edge. Outputs show reset values in the cycle after rst_n is sampled low.

## Configuration
- INV_SYN_RR_EN defined: round-robin arbitration.
  - Both requesters valid in IDLE: grant goes to the requester ≠ last_id.
  - One requester valid: grant goes to it.
  - Because last_id resets to 1, requester 0 wins the first tie after reset.
- INV_SYN_RR_EN undefined: fixed priority.
  - Requester 0 always wins when valid; requester 1 is granted only when req0_valid is low.
  - last_id is unused.

## Test plan
- Reset: hold rst_n low for 2 cycles with both valids high. Required: both readies = 0, res_valid = 0, res_sum = 0, res_id = 0, busy = 0. After release, req0_ready = 1 in the first IDLE cycle.
- Single word: req0_word = 12'b01_10_11_01_10_11 ([1,2,3,1,2,3]) accepted at T, res_ready held high. Required: res_valid = 1 at T+16, res_sum = 3, res_id = 0, busy low at T+17.
- Contention:
  - Stimulus: right after reset, req0_word = [0,3,2,1,0,3] and req1_word = [2,3,3,0,0,1], both valid.
  - With INV_SYN_RR_EN: first result is sum 6 / id 0, second is sum 9 / id 1. A new req0 word held valid alongside req1 is then served after req1.
  - Without INV_SYN_RR_EN: while req0 keeps supplying words, req1_ready never rises.
- Backpressure: same word as the single-word scenario, res_ready held low for 5 cycles after res_valid rises. Required: res_valid, res_sum = 3 and res_id stay stable, both readies stay 0, and IDLE is reached 1 cycle after res_ready rises.
- Reset mid-operation: assert rst_n low at cycle T+7 of a run. Required: next cycle res_valid = 0 and busy = 0, and no result appears for the dropped word. A following word [3,3,2,2,1,0] gives res_sum = 13.
- Boundaries: word all zeros gives res_sum = 0. Word [1,2,3,1,2,3] with N=6 checks the i/j wrap at every row.
